// File: rtl/dist_tree_pkg.sv
// Shared helpers for the pipelined distribution tree: depth math and the dummy word
// that fills unselected leaves.
package dist_tree_pkg;

  localparam int DUMMY_MAX_W = 1024;
  localparam logic DUMMY_BIT = 1'b0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // A single output still needs one register stage.
  function automatic int dist_levels(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Dummy payload, right-justified to w bits (w <= DUMMY_MAX_W).
  function automatic logic [DUMMY_MAX_W-1:0] dummy_word(input int w);
    return {DUMMY_MAX_W{DUMMY_BIT}} >> (DUMMY_MAX_W - w);
  endfunction

endpackage

// File: rtl/dist_tree_node.sv
// Registered 1-to-2 split: the low half of the mask feeds child lo, the high half child hi.
module dist_tree_node #(
  parameter int M  = 2,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            vld,
  input  logic [DW-1:0]   data,
  input  logic [M-1:0]    mask,
  output logic            vld_lo,
  output logic            vld_hi,
  output logic [DW-1:0]   data_lo,
  output logic [DW-1:0]   data_hi,
  output logic [M/2-1:0]  mask_lo,
  output logic [M/2-1:0]  mask_hi
);
  import dist_tree_pkg::*;

  localparam int H = M / 2;
  localparam logic [DW-1:0] DUMMY = DW'(dummy_word(DW));

  logic nxt_lo, nxt_hi;

  assign nxt_lo = vld & (|mask[H-1:0]);
  assign nxt_hi = vld & (|mask[M-1:H]);

  // Invalid children register the dummy word so no stale payload travels down.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_lo  <= 1'b0;
      vld_hi  <= 1'b0;
      data_lo <= '0;
      data_hi <= '0;
      mask_lo <= '0;
      mask_hi <= '0;
    end else if (en) begin
      vld_lo  <= nxt_lo;
      vld_hi  <= nxt_hi;
      data_lo <= nxt_lo ? data : DUMMY;
      data_hi <= nxt_hi ? data : DUMMY;
      mask_lo <= mask[H-1:0];
      mask_hi <= mask[M-1:H];
    end
  end

endmodule

// File: rtl/dist_tree_pipe.sv
// Pipelined 1-to-N multicast tree, LEVELS registered split stages from input to leaves.
// DIST_TREE_ZERO_BCAST_EN: an all-zero destination mask broadcasts to every output.
module dist_tree_pipe #(
  parameter int NUM_OUTPUT_DATA = 8,
  parameter int DATA_WIDTH      = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_en,
  input  logic                                  i_valid,
  input  logic [DATA_WIDTH-1:0]                 i_data_bus,
  input  logic [NUM_OUTPUT_DATA-1:0]            i_dest,
  output logic [NUM_OUTPUT_DATA-1:0]            o_valid,
  output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
  output logic                                  o_busy
);
  import dist_tree_pkg::*;

  localparam int LEVELS = dist_levels(NUM_OUTPUT_DATA);
  localparam int P      = 1 << LEVELS;

  logic [P-1:0]      dest_pad, dest_eff;
  logic              root_vld;
  logic [LEVELS-1:0] lvl_busy;

  // Padded leaves never get selected.
  assign dest_pad = P'(i_dest);

  always_comb begin
    dest_eff = dest_pad;
`ifdef DIST_TREE_ZERO_BCAST_EN
    if (dest_pad == '0) dest_eff = P'({NUM_OUTPUT_DATA{1'b1}});
`endif
  end

  assign root_vld = i_valid & (|dest_eff);
  assign o_busy   = |lvl_busy;

  // Level l holds 2^(l+1) registered children, each carrying a P>>(l+1) bit sub-mask.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NN = 1 << l;
    localparam int M  = P >> l;

    logic [2*NN-1:0]                 vld;
    logic [2*NN-1:0][DATA_WIDTH-1:0] data;
    logic [2*NN-1:0][M/2-1:0]        mask;

    assign lvl_busy[l] = |vld;

    for (genvar k = 0; k < NN; k++) begin : g_node
      logic                  p_vld;
      logic [DATA_WIDTH-1:0] p_data;
      logic [M-1:0]          p_mask;

      if (l == 0) begin : g_root
        assign p_vld  = root_vld;
        assign p_data = i_data_bus;
        assign p_mask = dest_eff;
      end else begin : g_inner
        assign p_vld  = g_lvl[l-1].vld[k];
        assign p_data = g_lvl[l-1].data[k];
        assign p_mask = g_lvl[l-1].mask[k];
      end

      dist_tree_node #(.M(M), .DW(DATA_WIDTH)) u_node (
        .clk     (clk),
        .rst     (rst),
        .en      (i_en),
        .vld     (p_vld),
        .data    (p_data),
        .mask    (p_mask),
        .vld_lo  (vld[2*k]),
        .vld_hi  (vld[2*k+1]),
        .data_lo (data[2*k]),
        .data_hi (data[2*k+1]),
        .mask_lo (mask[2*k]),
        .mask_hi (mask[2*k+1])
      );
    end

    if (l == LEVELS - 1) begin : g_leaf
      for (genvar j = 0; j < NUM_OUTPUT_DATA; j++) begin : g_out
        assign o_valid[j]                             = vld[j];
        assign o_data_bus[j*DATA_WIDTH +: DATA_WIDTH] = data[j];
      end

      logic [2*NN-1:0] unused_leaf_mask;
      assign unused_leaf_mask = mask;

      if (P > NUM_OUTPUT_DATA) begin : g_pad
        logic unused_pad_data;
        assign unused_pad_data = |data[P-1:NUM_OUTPUT_DATA];
      end
    end
  end

endmodule
